// File: rtl/divisor_secuencial_if.sv
// rtl/divisor_secuencial_if.sv - init/done handshake and operand/result bundle for the sequential divider
//
// Signals:
//   init  start request, sampled only while the divider is idle
//   DV    unsigned dividend, captured on the accept edge
//   DR    unsigned divisor, captured on the accept edge
//   quot  quotient of the last operation (registered)
//   rem   remainder of the last operation (registered)
//   done  one-cycle completion pulse (registered)
//   busy  high while the divider is not idle
//   div0  divide-by-zero flag of the last operation (registered)
// The master modport is the requester; the slave modport is the divider.
interface divisor_secuencial_if #(
    parameter int WIDTH = 3
);
    logic             init;
    logic [WIDTH-1:0] DV;
    logic [WIDTH-1:0] DR;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             done;
    logic             busy;
    logic             div0;

    modport master (
        output init, DV, DR,
        input  quot, rem, done, busy, div0
    );

    modport slave (
        input  init, DV, DR,
        output quot, rem, done, busy, div0
    );
endinterface

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - sequential restoring shift-subtract divider with init/done handshake
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous reset, active-high, highest priority
//   bus  divisor_secuencial_if slave modport (init, DV, DR in; quot, rem, done, busy, div0 out)
//
// One quotient bit is produced per SHIFT/SUB pair, so a normal division takes
// 2*WIDTH+1 edges from accept to the visible done pulse. A zero divisor skips
// the iteration entirely and reports quot = all ones, rem = dividend.
module divisor_secuencial #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    divisor_secuencial_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB,
        END1
    } state_t;

    state_t           state;
    logic [WIDTH:0]   a;      // partial remainder, one guard bit above the divisor width
    logic [WIDTH-1:0] q;      // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] m;      // captured divisor
    logic [CW-1:0]    cnt;    // quotient bits still to produce

    logic [WIDTH:0]   m_ext;
    logic             a_ge_m;

    assign m_ext  = {1'b0, m};
    assign a_ge_m = (a >= m_ext);

    // busy decodes the state only, so it is the one output not registered
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a        <= '0;
            q        <= '0;
            m        <= '0;
            cnt      <= '0;
            bus.quot <= '0;
            bus.rem  <= '0;
            bus.done <= 1'b0;
            bus.div0 <= 1'b0;
        end else begin
            // done is only raised by the END1 edge, so it lasts exactly one cycle
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.init) begin
                        a   <= '0;
                        q   <= bus.DV;
                        m   <= bus.DR;
                        cnt <= CW'(WIDTH);
                        if (bus.DR == '0) begin
                            bus.div0 <= 1'b1;
                            state    <= END1;
                        end else begin
                            bus.div0 <= 1'b0;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    {a, q} <= {a[WIDTH-1:0], q, 1'b0};
                    state  <= SUB;
                end
                SUB: begin
                    // restoring step: only commit the subtraction when it does not go negative
                    if (a_ge_m) begin
                        a    <= a - m_ext;
                        q[0] <= 1'b1;
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= END1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                END1: begin
                    if (bus.div0) begin
                        // the untouched dividend is still sitting in q
                        bus.quot <= '1;
                        bus.rem  <= q;
                    end else begin
                        bus.quot <= q;
                        bus.rem  <= a[WIDTH-1:0];
                    end
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Sequential restoring shift-subtract divider. It is the inverse operation of the team's shift-add multiplier and uses the same init/done handshake.
- Takes an unsigned dividend DV and divisor DR. Produces quotient and remainder after a fixed number of cycles, one quotient bit per SHIFT/SUB pair.
- Used by the datapath wherever the multiplier's result must be decomposed back into its factors, or a ratio is needed.

Parameters:
- WIDTH, 3, bit width of DV, DR, quot and rem (must be >= 2).

Ports:
- clk    in   1      clock; all state changes on the rising edge
- rst    in   1      synchronous reset, active-high
- init   in   1      start request; sampled only in IDLE
- DV     in   WIDTH  dividend (unsigned); captured on the accept edge
- DR     in   WIDTH  divisor (unsigned); captured on the accept edge
- quot   out  WIDTH  quotient (registered)
- rem    out  WIDTH  remainder (registered)
- done   out  1      one-cycle completion pulse (registered)
- busy   out  1      high while state != IDLE (combinational state decode)
- div0   out  1      divide-by-zero flag for the last operation (registered)

Behaviour:
- Reset: on any edge with rst=1:
  - state = IDLE; quot = 0; rem = 0; done = 0; div0 = 0.
  - Internal A, Q, M and cnt are cleared.
  - rst has priority over all other inputs. Reset mid-operation aborts the division with no done pulse.
- Internal registers:
  - A: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, dividend/quotient.
  - M: WIDTH bits, divisor.
  - cnt: ceil(log2(WIDTH+1)) bits.
- IDLE:
  - done = 0.
  - If init=1: A = 0, Q = DV, M = DR, cnt = WIDTH, div0 = 0.
  - If DR == 0: div0 = 1, go to END1. Otherwise go to SHIFT.
  - If init=0: stay in IDLE; quot, rem and div0 hold.
- SHIFT: {A,Q} = {A,Q} << 1 (Q[0] becomes 0), then go to SUB.
- SUB:
  - If A >= {1'b0,M}: A = A - {1'b0,M} and Q[0] = 1. Otherwise A and Q are unchanged.
  - cnt = cnt - 1. If cnt was 1, go to END1; otherwise go to SHIFT.
- END1:
  - Normal case: quot = Q, rem = A[WIDTH-1:0].
  - Divide-by-zero case: quot = all ones, rem = DV as captured (held in Q).
  - done = 1, then go to IDLE.
- done: high for exactly the one cycle following the END1 edge; cleared by the next edge in IDLE.
- Latency:
  - Normal: done is visible 2*WIDTH+1 edges after the accept edge (7 for WIDTH=3).
  - DR == 0: done is visible 1 edge after the accept edge.
- init while busy=1 is ignored and not queued. init held high continuously restarts the operation on the first IDLE edge after done; back-to-back operations are allowed.
- A never exceeds WIDTH bits after SUB. rem < DR is always guaranteed when DR != 0.
- DV and DR changing after the accept edge have no effect on the result.
- Invariant on done: DV_captured == quot*DR + rem whenever div0 = 0.
- No combinational path from inputs to outputs except busy (from state only).

Test Plan:
- WIDTH=3, DV=7, DR=2, init pulse -> done exactly 7 cycles after accept; quot=3, rem=1, div0=0; busy high for 7 cycles.
- WIDTH=3, DV=2, DR=5 -> quot=0, rem=2. Also DV=6, DR=3 -> quot=2, rem=0. Also DV=7, DR=1 -> quot=7, rem=0.
- WIDTH=3, DV=5, DR=0 -> done 1 cycle after accept; div0=1, quot=7, rem=5. A following DV=4, DR=2 clears div0 and gives quot=2, rem=0.
- Start DV=7, DR=3; pulse init again in cycle 3 with DV=1, DR=1 -> second init ignored; result quot=2, rem=1. Hold init high afterwards -> next operation starts on the first IDLE edge after done.
- Start DV=6, DR=2; assert rst in cycle 4 -> no done pulse; quot=0, rem=0, busy=0. A new init afterwards yields a correct result.
- WIDTH=4 exhaustive sweep over all DV, and DR 1..15, against a reference model: quot=DV/DR, rem=DV%DR, done latency 9 cycles, single-cycle done pulse every time.
